// File: rtl/mac_beam_sched.sv
// Beam scheduler in front of a complex MAC array.
// Each accepted antenna vector is held and replayed once per active beam.
// The matching code-word RAM address is issued one cycle ahead of the vector,
// and a tag delay line reports which beam each MAC sum belongs to.
//
// Input handshake: a vector transfers on any rising i_clk where i_rvalid and
// o_rready are both high. o_rready never depends on i_rvalid. i_beam_num is
// sampled on that same edge. The sum side has no backpressure: every cycle
// with o_sum_valid high carries exactly one sum.
module mac_beam_sched #(
    parameter int ANT     = 32,
    parameter int IW      = 32,
    parameter int BEAMS   = 16,
    parameter int MAC_LAT = 9,
    localparam int BW     = $clog2(BEAMS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ANT*IW-1:0] i_ants_data,
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [BW:0]       i_beam_num,
    output logic [BW-1:0]     o_cw_raddr,
    output logic [ANT*IW-1:0] o_mac_data,
    output logic              o_mac_valid,
    output logic              o_sum_valid,
    output logic [BW-1:0]     o_sum_beam,
    output logic              o_sum_last,
    output logic              o_busy,
    output logic              o_dbg_state
);

    localparam logic [BW:0] BEAM_MAX = (BW+1)'(BEAMS);
    localparam logic [BW:0] NB_ONE   = (BW+1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [BW-1:0]       beam_cnt;
    logic [BW-1:0]       last_idx;
    logic [BW-1:0]       raddr_q;
    logic [ANT*IW-1:0]   hold_q;
    logic                rdy_en;
    logic                at_last;
    logic                accept;
    logic [BW-1:0]       nb_m1_in;

    // Stage aligned with the RAM read data (one cycle after address issue).
    logic                mac_valid_q;
    logic [BW-1:0]       mac_beam_q;
    logic                mac_last_q;
    logic [ANT*IW-1:0]   mac_data_q;

    // Tag delay line matching the MAC pipeline depth.
    logic [MAC_LAT-1:0]          tag_v;
    logic [MAC_LAT-1:0][BW-1:0]  tag_b;
    logic [MAC_LAT-1:0]          tag_l;

    assign at_last  = (state == RUN) && (beam_cnt == last_idx);
    assign o_rready = rdy_en && ((state == IDLE) || at_last);
    assign accept   = i_rvalid && o_rready;

    // Clamp the requested beam count to 1..BEAMS; 0 or out of range means all beams.
    always_comb begin
        nb_m1_in = BW'(BEAMS - 1);
        if ((i_beam_num != '0) && (i_beam_num <= BEAM_MAX))
            nb_m1_in = BW'(i_beam_num - NB_ONE);
    end

    // Hold o_rready low until the first clock edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    // Scheduler FSM: load a vector, then walk the beam counter once per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            beam_cnt <= '0;
            last_idx <= '0;
            raddr_q  <= '0;
            hold_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_q   <= i_ants_data;
                        last_idx <= nb_m1_in;
                        beam_cnt <= '0;
                        raddr_q  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (at_last) begin
                        if (accept) begin
                            // Seamless restart: the next vector's beam 0 follows directly.
                            hold_q   <= i_ants_data;
                            last_idx <= nb_m1_in;
                            beam_cnt <= '0;
                            raddr_q  <= '0;
                        end else begin
                            // The address register keeps its last value while idle.
                            state <= IDLE;
                        end
                    end else begin
                        beam_cnt <= beam_cnt + BW'(1);
                        raddr_q  <= beam_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay the issue by one cycle to line up with the code-word RAM output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mac_valid_q <= 1'b0;
            mac_beam_q  <= '0;
            mac_last_q  <= 1'b0;
            mac_data_q  <= '0;
        end else begin
            mac_valid_q <= (state == RUN);
            mac_beam_q  <= beam_cnt;
            mac_last_q  <= at_last;
            // Only reloaded while issuing, so the MAC input stays stable per vector.
            if (state == RUN)
                mac_data_q <= hold_q;
        end
    end

    // Shift beam tags alongside the MAC pipeline so each sum knows its beam.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_v <= '0;
            tag_b <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= mac_valid_q;
            tag_b[0] <= mac_valid_q ? mac_beam_q : '0;
            tag_l[0] <= mac_valid_q & mac_last_q;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    assign o_cw_raddr  = raddr_q;
    assign o_mac_data  = mac_data_q;
    assign o_mac_valid = mac_valid_q;
    assign o_sum_valid = tag_v[MAC_LAT-1];
    assign o_sum_beam  = tag_b[MAC_LAT-1];
    assign o_sum_last  = tag_l[MAC_LAT-1];
    assign o_busy      = (state != IDLE) || mac_valid_q || (|tag_v);
    assign o_dbg_state = (state == RUN);

endmodule

// File: tb/tb_mac_beam_sched.sv
// Bench for mac_beam_sched: directed scenarios plus random traffic, checked
// against a cycle-indexed schedule derived from the acceptance timing rules.
module tb_mac_beam_sched;

    localparam int ANT     = 4;
    localparam int IW      = 16;
    localparam int BEAMS   = 16;
    localparam int MAC_LAT = 9;
    localparam int BW      = $clog2(BEAMS);
    localparam int DW      = ANT * IW;
    localparam int MAXC    = 2048;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b1;
    logic [DW-1:0]   i_ants_data = '0;
    logic            i_rvalid = 1'b0;
    logic            o_rready;
    logic [BW:0]     i_beam_num = '0;
    logic [BW-1:0]   o_cw_raddr;
    logic [DW-1:0]   o_mac_data;
    logic            o_mac_valid;
    logic            o_sum_valid;
    logic [BW-1:0]   o_sum_beam;
    logic            o_sum_last;
    logic            o_busy;
    logic            o_dbg_state;

    mac_beam_sched #(
        .ANT(ANT), .IW(IW), .BEAMS(BEAMS), .MAC_LAT(MAC_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ants_data(i_ants_data),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_beam_num(i_beam_num),
        .o_cw_raddr(o_cw_raddr), .o_mac_data(o_mac_data),
        .o_mac_valid(o_mac_valid), .o_sum_valid(o_sum_valid),
        .o_sum_beam(o_sum_beam), .o_sum_last(o_sum_last), .o_busy(o_busy),
        .o_dbg_state(o_dbg_state)
    );

    // clock
    always #5 i_clk = ~i_clk;

    // scoreboard state
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int free_cycle = 0;
    int busy_end = -1;
    logic [BW-1:0] last_addr;
    logic          ex_issue [MAXC];
    logic [BW-1:0] ex_ab    [MAXC];
    logic          ex_mv    [MAXC];
    logic [DW-1:0] ex_md    [MAXC];
    logic          ex_sv    [MAXC];
    logic [BW:0]   exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            ex_issue[i] = 1'b0;
            ex_ab[i]    = '0;
            ex_mv[i]    = 1'b0;
            ex_md[i]    = '0;
            ex_sv[i]    = 1'b0;
        end
        exp_q.delete();
        last_addr = '0;
        busy_end  = -1;
    endtask

    // A vector accepted in cycle t with n beams: beam b is addressed at t+1+b,
    // reaches the MAC at t+2+b and its sum leaves at t+2+MAC_LAT+b.
    task automatic schedule(input int t, input logic [BW:0] bn, input logic [DW-1:0] d);
        int n;
        n = (bn == 0 || int'(bn) > BEAMS) ? BEAMS : int'(bn);
        for (int b = 0; b < n; b++) begin
            ex_issue[t+1+b] = 1'b1;
            ex_ab[t+1+b]    = BW'(b);
            ex_mv[t+2+b]    = 1'b1;
            ex_md[t+2+b]    = d;
            ex_sv[t+2+MAC_LAT+b] = 1'b1;
            exp_q.push_back({(b == n-1) ? 1'b1 : 1'b0, BW'(b)});
        end
        free_cycle = t + n;
        busy_end   = t + n + 1 + MAC_LAT;
    endtask

    task automatic check_outputs();
        logic [BW-1:0] ea;
        logic [BW:0]   et;
        check("rready", o_rready, cyc >= free_cycle);
        ea = ex_issue[cyc] ? ex_ab[cyc] : last_addr;
        check("cw_raddr", o_cw_raddr, ea);
        last_addr = ea;
        check("dbg_state", o_dbg_state, ex_issue[cyc]);
        check("mac_valid", o_mac_valid, ex_mv[cyc]);
        if (ex_mv[cyc])
            check("mac_data", o_mac_data, ex_md[cyc]);
        check("sum_valid", o_sum_valid, ex_sv[cyc]);
        if (ex_sv[cyc] && exp_q.size() > 0) begin
            et = exp_q.pop_front();
            check("sum_tag", {o_sum_last, o_sum_beam}, et);
        end else if (!ex_sv[cyc]) begin
            check("sum_last_idle", o_sum_last, 1'b0);
        end
        check("busy", o_busy, cyc <= busy_end);
    endtask

    task automatic check_zeros();
        check("rst_rready", o_rready, 1'b0);
        check("rst_raddr", o_cw_raddr, '0);
        check("rst_mac_valid", o_mac_valid, 1'b0);
        check("rst_mac_data", o_mac_data, '0);
        check("rst_sum_valid", o_sum_valid, 1'b0);
        check("rst_sum_beam", o_sum_beam, '0);
        check("rst_sum_last", o_sum_last, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_state", o_dbg_state, 1'b0);
    endtask

    // driver: present inputs for the current cycle, then advance and check
    task automatic run_cycle(input logic rv, input logic [BW:0] bn);
        logic [DW-1:0] d;
        if (cyc + 40 >= MAXC) begin
            $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        d = {$urandom, $urandom};
        i_rvalid    = rv;
        i_beam_num  = bn;
        i_ants_data = d;
        if (rv && cyc >= free_cycle)
            schedule(cyc, bn, d);
        @(posedge i_clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic apply_reset(input int n);
        i_rst_n  = 1'b0;
        i_rvalid = 1'b0;
        #1;
        check_zeros();
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            check_zeros();
        end
        model_clear();
        free_cycle = cyc + 1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic        rv;
        logic [BW:0] bn;
        model_clear();
        #2;
        apply_reset(2);

        // single vector, all 16 beams, then drain
        run_cycle(1'b1, 5'd16);
        repeat (30) run_cycle(1'b0, 5'd16);

        // back-to-back with 4 beams
        repeat (20) run_cycle(1'b1, 5'd4);
        repeat (20) run_cycle(1'b0, 5'd4);

        // clamping: 0 and 17 mean 16, 1 means a single beam
        run_cycle(1'b1, 5'd0);
        repeat (20) run_cycle(1'b0, 5'd0);
        run_cycle(1'b1, 5'd17);
        repeat (20) run_cycle(1'b0, 5'd0);
        repeat (8) run_cycle(1'b1, 5'd1);
        repeat (14) run_cycle(1'b0, 5'd1);

        // beam count changes while a vector is in progress
        repeat (4) run_cycle(1'b1, 5'd8);
        repeat (12) run_cycle(1'b1, 5'd3);
        repeat (16) run_cycle(1'b0, 5'd3);

        // reset while beam 5 of 16 is being issued
        run_cycle(1'b1, 5'd16);
        repeat (5) run_cycle(1'b0, 5'd16);
        apply_reset(2);
        repeat (25) run_cycle(1'b0, 5'd16);

        // idle gap of three cycles between two vectors
        run_cycle(1'b1, 5'd5);
        repeat (7) run_cycle(1'b0, 5'd5);
        run_cycle(1'b1, 5'd5);
        repeat (25) run_cycle(1'b0, 5'd5);

        // random traffic
        repeat (400) begin
            rv = ($urandom_range(0, 3) != 0);
            bn = (BW+1)'($urandom_range(0, BEAMS + 2));
            run_cycle(rv, bn);
        end
        repeat (30) run_cycle(1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
